// File: rtl/count_seq.sv
// count_seq: round-robin sequencer for a W-bit up/down step counter.
// Two requesters each present a target. The winner is granted, its target is latched,
// and the internal counter walks to it over the shortest modular path in steps of 1 or 2.
// A one-cycle done pulse goes to the winner when the count reaches the target.
//
// Ports:
//   clk      - clock, rising edge
//   nrst     - asynchronous active-low reset
//   i_req    - request per requester, held until its done
//   i_tgt0   - target of requester 0, sampled on grant only
//   i_tgt1   - target of requester 1, sampled on grant only
//   o_gnt    - one-hot grant, grant edge through the done cycle
//   o_done   - one-cycle completion pulse to the granted requester
//   o_busy   - sequencer not idle
//   o_cnt    - current count
//   o_down   - direction this MOVE cycle (1 = decrement), 0 otherwise
//   o_step   - step size this MOVE cycle (1 = by 2), 0 otherwise
module count_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [1:0]   i_req,
    input  logic [W-1:0] i_tgt0,
    input  logic [W-1:0] i_tgt1,
    output logic [1:0]   o_gnt,
    output logic [1:0]   o_done,
    output logic         o_busy,
    output logic [W-1:0] o_cnt,
    output logic         o_down,
    output logic         o_step
);

    typedef enum logic [1:0] {StIdle, StMove, StDone} state_e;

    state_e       r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_tgt;
    logic [1:0]   r_gnt;
    logic [1:0]   r_done;
    logic         r_ptr;   // requester favoured when both request

    logic [W-1:0] w_du;
    logic [W-1:0] w_dd;
    logic         w_down;
    logic [W-1:0] w_d;
    logic         w_step;
    logic [W-1:0] w_mag;
    logic [W-1:0] w_cnt_nxt;
    logic         w_sel;
    logic [1:0]   w_sel_oh;
    logic [W-1:0] w_tgt_sel;

    always_comb begin
        // Modular distances both ways; a tie goes up.
        w_du      = r_tgt - r_cnt;
        w_dd      = r_cnt - r_tgt;
        w_down    = (w_dd < w_du);
        w_d       = w_down ? w_dd : w_du;
        // Stepping by 2 only when at least 2 away means we never overshoot.
        w_step    = (w_d >= W'(2));
        w_mag     = w_step ? W'(2) : W'(1);
        w_cnt_nxt = w_down ? (r_cnt - w_mag) : (r_cnt + w_mag);

        if (i_req == 2'b11) begin
            w_sel = r_ptr;
        end else begin
            w_sel = i_req[1];
        end
        w_sel_oh  = {w_sel, ~w_sel};
        w_tgt_sel = w_sel ? i_tgt1 : i_tgt0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_tgt   <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (|i_req) begin
                        r_gnt <= w_sel_oh;
                        r_tgt <= w_tgt_sel;
                        if (w_tgt_sel == r_cnt) begin
                            r_state <= StDone;
                            r_done  <= w_sel_oh;
                        end else begin
                            r_state <= StMove;
                        end
                    end
                end
                StMove: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_tgt) begin
                        r_state <= StDone;
                        r_done  <= r_gnt;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_gnt   <= 2'b00;
                    r_done  <= 2'b00;
                    // Hand priority to the requester that was not just served.
                    r_ptr   <= r_gnt[0];
                end
                default: begin
                    r_state <= StIdle;
                    r_gnt   <= 2'b00;
                    r_done  <= 2'b00;
                end
            endcase
        end
    end

    assign o_gnt  = r_gnt;
    assign o_done = r_done;
    assign o_busy = (r_state != StIdle);
    assign o_cnt  = r_cnt;
    assign o_down = (r_state == StMove) & w_down;
    assign o_step = (r_state == StMove) & w_step;

endmodule
